io_mem_arbiter: RTL and testbench
=================================

// Module: io_mem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the byte-addressed big-endian IO memory. Shares the memory's
//  single dm_cs/dm_wr/dm_rd/Addr/D_In port between the CPU (port 0) and an IO device (port 1).
//  Registers read data and returns it with a one-cycle ack. Owns the interrupt path: latches device interrupts
//  and holds intr until the CPU acknowledges, gated by the ie enable.
// PARAMETERS
//  MEM_BYTES  4096  memory size in bytes; an access is legal only when addr+3 < MEM_BYTES
//  DATA_W     32    data width; fixed at 32, the memory returns 4 bytes per access
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  req0,req1   in   1   access request, held high until ackN
//  wr0,wr1     in   1   1 = write, 0 = read; sampled with reqN
//  addr0,addr1 in   32  byte address; must be word-aligned (addr[1:0]==0)
//  wdata0/1    in   32  write data
//  ack0,ack1   out  1   one-cycle completion pulse
//  err0,err1   out  1   with ackN: access rejected, because it was misaligned or out of range
//  rdata       out  32  read data; valid while ack0 or ack1 is high
//  dm_cs,dm_wr,dm_rd out 1  memory strobes
//  mem_addr    out  32  memory address
//  mem_din     out  32  memory write data
//  mem_dout    in   32  memory read data, combinational from the memory
//  dev_int     in   1   device interrupt request, level; rising edge is detected
//  ie          in   1   interrupt enable, from the CPU
//  int_ack     in   1   CPU interrupt acknowledge, one-cycle pulse
//  intr        out  1   interrupt to the CPU = pend & ie
// BEHAVIOUR
//  Reset
//   - State = IDLE. All outputs 0: ack*, err*, dm_*, rdata, mem_addr, mem_din.
//   - pend = 0, last_grant = 1, so the CPU wins the first tie.
//  FSM states: IDLE, ACCESS, DONE
//   IDLE
//    - No request: stay in IDLE.
//    - Exactly one reqN: grant N.
//    - Both requests: grant the port that is not last_grant (round robin).
//    - On grant: latch addr, wr and wdata of the winner. Check the address:
//      aligned and addr+3 < MEM_BYTES -> ACCESS; otherwise -> DONE with err set.
//   ACCESS (exactly 1 cycle)
//    - dm_cs = 1; dm_wr = wr; dm_rd = ~wr; mem_addr and mem_din come from the latch.
//    - On a read, mem_dout is captured into rdata at the clock edge.
//    - Next state: DONE.
//   DONE (1 cycle)
//    - ackN = 1 for the granted port; errN = 1 if the access was rejected.
//    - rdata holds the captured value; it is 0 on a write or an error.
//    - Update last_grant = N. Next state: IDLE.
//  Latency
//   - reqN sampled in IDLE at edge T -> ACCESS in T+1 -> ackN in T+2.
//   - Error path: ackN/errN in T+1.
//   - Back-to-back: a requester that drops req after ack and re-raises it is served again 3 cycles later.
//  Strobe rules
//   - dm_* are 0 in every state except ACCESS.
//   - dm_wr and dm_rd are never high together.
//  Requester rules
//   - A requester must not change addr/wr/wdata while req is high.
//   - Dropping req before ack: the access still completes and the ack is still issued.
//  Interrupts
//   - dev_int is registered once (dev_q); rise = dev_int & ~dev_q.
//   - pend: set by rise, cleared by int_ack; rise and int_ack in the same cycle -> pend stays 1 (set wins).
//   - intr = pend & ie, registered, so intr follows pend/ie changes one cycle later.
//   - ie = 0 masks intr but leaves pend set; raising ie later asserts intr.
//  Reset mid-operation
//   - Any state -> IDLE immediately. Strobes drop asynchronously.
//   - The in-flight access is lost, with no ack.
//  Width rule
//   - The range check is done in 33 bits, so addr near 2^32 cannot wrap to legal.
// STRUCTURE
//  - Shared package io_pkg: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and MEM_BYTES default.
//  - One sub-module, io_int_latch: dev_int edge detect, pend, intr register.
//  - The arbiter FSM stays in this module.
// TESTING
//  1. req0 write addr 0x10 data 0xDEADBEEF, then req0 read addr 0x10 ->
//     dm_cs&dm_wr high for exactly 1 cycle; ack0 at T+2; rdata = 0xDEADBEEF.
//  2. req0 and req1 raised in the same cycle from reset, both held -> port 0 is served first, then port 1;
//     continuous contention alternates 0,1,0,1.
//  3. req1 read addr 0x12 (misaligned), then addr 0xFFC+4=0x1000 -> ack1&err1 at T+1,
//     no dm_cs pulse, rdata = 0.
//  4. dev_int rises with ie=1 -> intr=1 two cycles later; int_ack pulse -> intr=0;
//     dev_int re-rise in the same cycle as int_ack -> intr stays 1.
//  5. ie=0 with dev_int rise -> intr=0; ie->1 -> intr=1 the next cycle.
//  6. rst_n low during ACCESS -> dm_cs drops immediately, no ack;
//     after release, a new req0 completes normally.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the IO memory arbiter: FSM encoding, memory size and
// the legal-access check used at grant time.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int IO_MEM_BYTES = 4096;

  // Done in 33 bits so an address near 2^32 cannot wrap into the legal range.
  function automatic logic addr_ok(input logic [31:0] addr, input int mem_bytes);
    logic [32:0] w_last;
    w_last = {1'b0, addr} + 33'd3;
    return (addr[1:0] == 2'b00) && (w_last < 33'(mem_bytes));
  endfunction

endpackage

// File: rtl/io_int_latch.sv
// Device interrupt path: rising-edge detect on dev_int, sticky pending bit
// cleared by the CPU acknowledge, and a registered enable-gated intr.
module io_int_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic dev_int,
  input  logic ie,
  input  logic int_ack,
  output logic intr
);

  logic r_dev_q;
  logic r_pend;
  logic r_intr;
  logic w_rise;

  assign w_rise = dev_int & ~r_dev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dev_q <= 1'b0;
      r_pend  <= 1'b0;
      r_intr  <= 1'b0;
    end else begin
      r_dev_q <= dev_int;
      // A new edge arriving with the acknowledge must not be lost.
      r_pend  <= w_rise | (r_pend & ~int_ack);
      r_intr  <= r_pend & ie;
    end
  end

  assign intr = r_intr;

endmodule

// File: rtl/io_mem_arbiter.sv
// Round-robin arbiter between the CPU (port 0) and an IO device (port 1) in front
// of the single-port IO memory, plus the device interrupt latch.
module io_mem_arbiter
  import io_pkg::*;
#(
  parameter int MEM_BYTES = IO_MEM_BYTES,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              dm_cs,
  output logic              dm_wr,
  output logic              dm_rd,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              dev_int,
  input  logic              ie,
  input  logic              int_ack,
  output logic              intr
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_gnt;
  logic              r_last;
  logic              r_wr;
  logic              r_err;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any;
  logic              w_sel;
  logic [31:0]       w_addr;
  logic              w_ok;

  assign w_any  = req0 | req1;
  // On contention the port that did not win last time goes next.
  assign w_sel  = (req0 & req1) ? ~r_last : req1;
  assign w_addr = w_sel ? addr1 : addr0;
  assign w_ok   = addr_ok(w_addr, MEM_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    dm_cs       = 1'b0;
    dm_wr       = 1'b0;
    dm_rd       = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = w_ok ? ACCESS : DONE;
      end
      ACCESS: begin
        dm_cs       = 1'b1;
        dm_wr       = r_wr;
        dm_rd       = ~r_wr;
        w_state_nxt = DONE;
      end
      DONE: begin
        ack0        = ~r_gnt;
        ack1        = r_gnt;
        err0        = ~r_gnt & r_err;
        err1        = r_gnt & r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_gnt   <= w_sel;
        r_wr    <= w_sel ? wr1 : wr0;
        r_addr  <= w_addr;
        r_wdata <= w_sel ? wdata1 : wdata0;
        r_err   <= ~w_ok;
        r_rdata <= '0;
      end
      if (r_state == ACCESS && !r_wr) r_rdata <= mem_dout;
      if (r_state == DONE)            r_last  <= r_gnt;
    end
  end

  assign rdata    = r_rdata;
  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;

  io_int_latch u_int (
    .clk     (clk),
    .rst_n   (rst_n),
    .dev_int (dev_int),
    .ie      (ie),
    .int_ack (int_ack),
    .intr    (intr)
  );

endmodule

// File: tb/tb_io_mem_arbiter.sv
// Scoreboard bench for io_mem_arbiter with a big-endian byte memory model.
module tb_io_mem_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic        dm_cs, dm_wr, dm_rd;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        dev_int, ie, int_ack, intr;

  int   errors = 0;
  int   checks = 0;
  int   cs_cnt = 0;
  int   wr_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   order_q[$];

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  io_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .dev_int(dev_int), .ie(ie), .int_ack(int_ack), .intr(intr)
  );

  always_comb begin
    logic [11:0] a;
    a        = mem_addr[11:0];
    mem_dout = {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
  end

  always @(posedge clk) begin
    if (dm_cs && dm_wr) begin
      mem[mem_addr[11:0]]         <= mem_din[31:24];
      mem[mem_addr[11:0] + 12'd1] <= mem_din[23:16];
      mem[mem_addr[11:0] + 12'd2] <= mem_din[15:8];
      mem[mem_addr[11:0] + 12'd3] <= mem_din[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ack(input int p, input logic e_act, input logic [31:0] rd_act);
    exp_t e;
    order_q.push_back(p);
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_ack port%0d: got ack want none", p);
    end else begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("err%0d", p), {31'd0, e_act}, {31'd0, e.err});
      chk($sformatf("rdata%0d", p), rd_act, e.rd);
    end
  endtask

  // Monitor: independent of stimulus, pops expectations as acks appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_cs) begin
        cs_cnt++;
        if (dm_wr) wr_cnt++;
        chk("strobe_excl", {31'd0, dm_wr ^ dm_rd}, 32'd1);
      end
      if (ack0 && ack1) chk("ack_both", 32'd1, 32'd0);
      if (ack0) check_ack(0, err0, rdata);
      if (ack1) check_ack(1, err1, rdata);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic ee, input logic [31:0] er, input int lat);
    exp_t e;
    int   n;
    logic got;
    e.err = ee; e.rd = er;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    tick();
    if (p == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick(); n++;
      got = (p == 0) ? ack0 : ack1;
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout port%0d: got no ack want ack", p);
    end else if (lat >= 0) chk($sformatf("latency%0d", p), n, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, {24'd0, ack0, ack1, err0, err1, dm_cs, dm_wr, dm_rd, intr}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_maddr"}, mem_addr | mem_din, 32'd0);
  endtask

  initial begin
    int c0, w0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    dev_int = 0; ie = 0; int_ack = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // Test 2 first, straight out of reset: CPU wins the first tie, then alternation.
    order_q.delete();
    fork
      begin
        access(0, 1'b1, 32'h20, 32'h11112222, 1'b0, 32'h0, 2);
        access(0, 1'b0, 32'h24, 32'h0,       1'b0, 32'h33334444, -1);
      end
      begin
        access(1, 1'b1, 32'h24, 32'h33334444, 1'b0, 32'h0, -1);
        access(1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h11112222, -1);
      end
    join
    repeat (2) tick();
    chk("order_len", order_q.size(), 4);
    if (order_q.size() == 4) begin
      chk("order0", order_q[0], 0);
      chk("order1", order_q[1], 1);
      chk("order2", order_q[2], 0);
      chk("order3", order_q[3], 1);
    end

    // Test 1: write then read back, one write strobe cycle.
    w0 = wr_cnt;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    chk("wr_pulse", wr_cnt - w0, 1);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);

    // Test 3: last legal word works; rejected accesses never touch memory.
    access(1, 1'b1, 32'hFFC, 32'h01234567, 1'b0, 32'h0, 2);
    access(1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h01234567, 2);
    c0 = cs_cnt;
    access(1, 1'b0, 32'h12,       32'h0, 1'b1, 32'h0, 1);
    access(1, 1'b0, 32'h1000,     32'h0, 1'b1, 32'h0, 1);
    access(1, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0, 1);
    access(0, 1'b1, 32'h1002,     32'hAAAAAAAA, 1'b1, 32'h0, 1);
    chk("err_no_cs", cs_cnt - c0, 0);

    // Test 4: interrupt set/clear, and set winning over a simultaneous ack.
    ie = 1'b1;
    tick(); dev_int = 1'b1;
    tick(); chk("intr_lat1", {31'd0, intr}, 0);
    tick(); chk("intr_lat2", {31'd0, intr}, 1);
    int_ack = 1'b1;
    tick(); int_ack = 1'b0; chk("intr_ack_hold", {31'd0, intr}, 1);
    tick(); chk("intr_cleared", {31'd0, intr}, 0);
    dev_int = 1'b0; tick(); tick();
    dev_int = 1'b1; tick(); tick();
    chk("intr_reset2", {31'd0, intr}, 1);
    dev_int = 1'b0; tick();
    dev_int = 1'b1; int_ack = 1'b1;
    tick(); int_ack = 1'b0;
    tick(); chk("set_wins_a", {31'd0, intr}, 1);
    tick(); chk("set_wins_b", {31'd0, intr}, 1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick(); tick(); chk("intr_clr2", {31'd0, intr}, 0);

    // Test 5: masked pending, unmasked later.
    dev_int = 1'b0; ie = 1'b0; tick(); tick();
    dev_int = 1'b1; tick(); tick(); tick();
    chk("intr_masked", {31'd0, intr}, 0);
    ie = 1'b1; tick();
    chk("intr_unmask", {31'd0, intr}, 1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick(); tick(); chk("intr_clr3", {31'd0, intr}, 0);

    // Test 6: reset during ACCESS aborts with no ack; a fresh access works.
    tick();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
    tick();
    chk("mid_cs", {31'd0, dm_cs}, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_cs", {29'd0, dm_cs, dm_wr, dm_rd}, 0);
    req0 = 1'b0;
    tick(); tick();
    check_reset_outputs("midrst");
    #2 rst_n = 1'b1;
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);

    repeat (3) tick();
    chk("q_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
